spi_reg_sequencer: RTL and testbench

SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

---
 rtl/spi_reg_pkg.sv | 15 +
 rtl/spi_byte_shifter.sv | 51 +++++
 rtl/spi_reg_sequencer.sv | 85 ++++++++
 tb/tb_spi_reg_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register sequencer.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_RD_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA
  } state_e;

  localparam int         RW_BIT     = 7;
  localparam int         ADDR_W_DEF = 7;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

endpackage

// File: rtl/spi_byte_shifter.sv
// Bit counter, RX shift register and TX load/shift path for one SPI byte lane.
module spi_byte_shifter
  import spi_reg_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso
);

  logic [2:0] bc_q, bc_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;

  // The last bit of a byte is taken straight from the pin so strobes fire on that edge.
  assign byte_done = (bc_q == 3'd7);
  assign rx_byte   = {shift_q, mosi};
  assign miso      = miso_q;

  always_comb begin
    bc_d    = bc_q + 3'd1;
    shift_d = {shift_q[5:0], mosi};
    tx_d    = {tx_q[6:0], 1'b0};
    miso_d  = tx_q[7];
    // tx_q keeps only the bits not yet driven; bit 7 goes out right after the load edge.
    if (tx_load) begin
      tx_d   = {tx_data[6:0], 1'b0};
      miso_d = tx_data[7];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bc_q    <= 3'd0;
      shift_q <= 7'd0;
      tx_q    <= DUMMY_BYTE;
      miso_q  <= 1'b0;
    end else begin
      bc_q    <= bc_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
    end
  end

endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI slave that turns command/data frames into register-bank read and write strobes.
module spi_reg_sequencer
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              w_SPI_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_Wr_En,
  output logic [7:0]        o_Reg_Wr_Data,
  output logic              o_Reg_Rd_En,
  input  logic [7:0]        i_Reg_Rd_Data,
  output logic [7:0]        o_Burst_Cnt
);

  // CS_n high aborts the frame exactly like reset, but the address survives it.
  logic frame_rst_n;
  assign frame_rst_n = i_Rst_L & ~i_SPI_CS_n;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        burst_q, burst_d;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic              wr_en, rd_en;

  spi_byte_shifter u_shifter (
    .clk       (w_SPI_Clk),
    .arst_n    (frame_rst_n),
    .mosi      (i_SPI_MOSI),
    .tx_load   (rd_en),
    .tx_data   (i_Reg_Rd_Data),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .miso      (o_SPI_MISO)
  );

  assign wr_en         = (state_q == ST_WR_DATA) && byte_done;
  assign rd_en         = ((state_q == ST_RD_DUMMY) || (state_q == ST_RD_DATA)) && byte_done;
  assign o_Reg_Wr_En   = wr_en;
  assign o_Reg_Rd_En   = rd_en;
  assign o_Reg_Wr_Data = rx_byte;
  assign o_Reg_Addr    = addr_q;
  assign o_Burst_Cnt   = burst_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    case (state_q)
      ST_CMD: begin
        if (byte_done) begin
          state_d = rx_byte[RW_BIT] ? ST_RD_DUMMY : ST_WR_DATA;
          addr_d  = rx_byte[ADDR_W-1:0];
        end
      end
      ST_RD_DUMMY: if (byte_done) state_d = ST_RD_DATA;
      default:     state_d = state_q;
    endcase
    if (wr_en || rd_en) addr_d = addr_q + ADDR_W'(1);
    // The dummy-phase read is a prefetch only, so it does not count as a data byte.
    if ((wr_en || ((state_q == ST_RD_DATA) && byte_done)) && (burst_q != 8'hFF))
      burst_d = burst_q + 8'd1;
  end

  always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q <= ST_CMD;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) addr_q <= '0;
    else if (!i_SPI_CS_n) addr_q <= addr_d;
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed frame-level bench for spi_reg_sequencer with a combinational bank model.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [6:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] burst;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_num;
  logic [7:0] miso_acc;

  int         wr_edge[$];
  logic [7:0] wr_addr[$];
  logic [7:0] wr_dat[$];
  int         rd_edge[$];
  logic [7:0] rd_addr[$];
  logic [7:0] miso_bytes[$];

  spi_reg_sequencer #(.ADDR_W(7)) dut (
    .w_SPI_Clk     (clk),
    .i_Rst_L       (rst_l),
    .i_SPI_CS_n    (cs_n),
    .i_SPI_MOSI    (mosi),
    .o_SPI_MISO    (miso),
    .o_Reg_Addr    (addr),
    .o_Reg_Wr_En   (wr_en),
    .o_Reg_Wr_Data (wr_data),
    .o_Reg_Rd_En   (rd_en),
    .i_Reg_Rd_Data (rd_data),
    .o_Burst_Cnt   (burst)
  );

  always #5 clk = ~clk;

  // Bank returns address + 0x10.
  assign rd_data = {1'b0, addr} + 8'h10;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    cs_n = 1'b0;
    edge_num = 0;
    wr_edge.delete(); wr_addr.delete(); wr_dat.delete();
    rd_edge.delete(); rd_addr.delete(); miso_bytes.delete();
  endtask

  // Called just after a falling edge; samples pre-edge state, then waits for the next falling edge.
  task automatic send_bit(input logic b);
    mosi = b;
    #1;
    edge_num++;
    miso_acc = {miso_acc[6:0], miso};
    if (wr_en) begin
      wr_edge.push_back(edge_num);
      wr_addr.push_back({1'b0, addr});
      wr_dat.push_back(wr_data);
    end
    if (rd_en) begin
      rd_edge.push_back(edge_num);
      rd_addr.push_back({1'b0, addr});
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    miso_bytes.push_back(miso_acc);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_l = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #1;
    check_val("rst_miso", miso, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_burst", burst, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_rd_en", rd_en, 0);
    @(negedge clk);
    rst_l = 1'b1;

    // Write 0x05: 0xA5, 0x3C
    start_frame();
    send_byte(8'h05); send_byte(8'hA5); send_byte(8'h3C);
    check_val("w1_burst", burst, 2);
    check_val("w1_wr_cnt", wr_edge.size(), 2);
    check_val("w1_rd_cnt", rd_edge.size(), 0);
    if (wr_edge.size() == 2) begin
      check_val("w1_edge0", wr_edge[0], 16);
      check_val("w1_edge1", wr_edge[1], 24);
      check_val("w1_addr0", wr_addr[0], 8'h05);
      check_val("w1_data0", wr_dat[0], 8'hA5);
      check_val("w1_addr1", wr_addr[1], 8'h06);
      check_val("w1_data1", wr_dat[1], 8'h3C);
    end
    check_val("w1_miso", miso_bytes[0] | miso_bytes[1] | miso_bytes[2], 0);
    end_frame();
    check_val("cs_burst_clr", burst, 0);
    check_val("cs_addr_hold", addr, 8'h07);

    // Read 0x02: dummy + 2 data bytes
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h82 : 8'h00);
    check_val("r1_rd_cnt", rd_edge.size(), 3);
    check_val("r1_wr_cnt", wr_edge.size(), 0);
    if (rd_edge.size() == 3) begin
      check_val("r1_edge0", rd_edge[0], 16);
      check_val("r1_edge1", rd_edge[1], 24);
      check_val("r1_edge2", rd_edge[2], 32);
      check_val("r1_addr0", rd_addr[0], 8'h02);
      check_val("r1_addr2", rd_addr[2], 8'h04);
    end
    check_val("r1_miso_cmd", miso_bytes[0], 8'h00);
    check_val("r1_miso_dummy", miso_bytes[1], 8'h00);
    check_val("r1_miso_d0", miso_bytes[2], 8'h12);
    check_val("r1_miso_d1", miso_bytes[3], 8'h13);
    check_val("r1_burst", burst, 2);
    end_frame();
    check_val("r1_miso_idle", miso, 0);

    // Write burst across the address wrap
    start_frame();
    send_byte(8'h7F); send_byte(8'h11); send_byte(8'h22);
    check_val("wrap_wr_cnt", wr_edge.size(), 2);
    if (wr_edge.size() == 2) begin
      check_val("wrap_addr0", wr_addr[0], 8'h7F);
      check_val("wrap_addr1", wr_addr[1], 8'h00);
      check_val("wrap_data1", wr_dat[1], 8'h22);
    end
    end_frame();

    // Partial data byte is dropped
    start_frame();
    send_byte(8'h10);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    end_frame();
    check_val("part_wr_cnt", wr_edge.size(), 0);
    check_val("part_wr_en", wr_en, 0);
    start_frame();
    send_byte(8'h33); send_byte(8'h44);
    check_val("after_wr_cnt", wr_edge.size(), 1);
    if (wr_edge.size() == 1) begin
      check_val("after_addr", wr_addr[0], 8'h33);
      check_val("after_data", wr_dat[0], 8'h44);
    end
    check_val("after_burst", burst, 1);
    end_frame();

    // Command-only write frame
    start_frame();
    send_byte(8'h20);
    end_frame();
    check_val("cmdonly_wr_cnt", wr_edge.size(), 0);
    check_val("cmdonly_addr", addr, 8'h20);

    // Reset in the middle of a read data byte
    start_frame();
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    check_val("mid_miso_d0", miso_bytes[2], 8'h11);
    check_val("mid_pre_miso", miso, 1);
    check_val("mid_pre_burst", burst, 1);
    check_val("mid_pre_addr", addr, 8'h03);
    #2;
    rst_l = 1'b0;
    #1;
    check_val("mid_rst_miso", miso, 0);
    check_val("mid_rst_addr", addr, 0);
    check_val("mid_rst_burst", burst, 0);
    check_val("mid_rst_rd_en", rd_en, 0);
    check_val("mid_rst_wr_en", wr_en, 0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;

    // 300-byte write burst saturates the byte counter
    start_frame();
    send_byte(8'h00);
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    check_val("sat_burst", burst, 255);
    check_val("sat_wr_cnt", wr_edge.size(), 300);
    if (wr_edge.size() == 300) begin
      check_val("sat_last_addr", wr_addr[299], 8'h2B);
      check_val("sat_last_data", wr_dat[299], 8'h2B);
    end
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
